// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// datapath select encodings and the control-strobe bundle.
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_BOOT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control/status bundle between the MIPS control unit (master) and datapath
// (slave). Counter signals exist only when MCTRL_PERF_EN is defined.
interface mips_mc_ctrl_if;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_en;
  logic [1:0]  pc_source;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        mem_to_reg;
  logic        reg_dst;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        illegal_op;
  logic [3:0]  state;
`ifdef MCTRL_PERF_EN
  logic [31:0] instr_count;
  logic [31:0] cycle_count;
`endif

  modport master (
    input  opcode, zero, mem_ready,
`ifdef MCTRL_PERF_EN
    output instr_count, cycle_count,
`endif
    output pc_en, pc_source, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
`ifdef MCTRL_PERF_EN
    input  instr_count, cycle_count,
`endif
    input  pc_en, pc_source, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           illegal_op, state
  );
endinterface

// File: rtl/mips_mc_ctrl_out_decode.sv
// Combinational map from (state, opcode, zero, mem_ready) to datapath
// strobes; pc_en/ir_write carry the Mealy terms.
module mctrl_out_decode
  import mctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_en     = mem_ready_i;
      end
      S_DECODE:   ctrl_o.alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.pc_source = PCS_ALUOUT;
        // bne takes the branch on a non-zero difference
        ctrl_o.pc_en     = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
      end
      S_JUMP: begin
        ctrl_o.pc_en     = 1'b1;
        ctrl_o.pc_source = PCS_JUMP;
      end
      S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: ctrl_o.reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: state register, next-state logic, sticky
// illegal-opcode flag; MCTRL_PERF_EN adds instruction and cycle counters.
module mips_mc_ctrl
  import mctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  mips_mc_ctrl_if.master bus
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BOOT;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (bus.opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_ADDI_EX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC:     state_d = S_R_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_BOOT;
    endcase
  end

  mctrl_out_decode u_out_decode (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .zero_i      (bus.zero),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  assign bus.pc_en      = ctrl.pc_en;
  assign bus.pc_source  = ctrl.pc_source;
  assign bus.iord       = ctrl.iord;
  assign bus.mem_read   = ctrl.mem_read;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.illegal_op = illegal_q;
  assign bus.state      = state_q;

`ifdef MCTRL_PERF_EN
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        retire;

  // Retirement is the return to FETCH from a terminal state; an illegal
  // opcode returns from DECODE and is deliberately excluded.
  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH) begin
      unique case (state_q)
        S_MEM_WB, S_MEM_WR, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
    instr_cnt_d = retire ? instr_cnt_q + 32'd1 : instr_cnt_q;
    cycle_cnt_d = (state_q != S_BOOT) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign bus.instr_count = instr_cnt_q;
  assign bus.cycle_count = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed, table-driven bench for mips_mc_ctrl.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    outs_t      o;
    logic       ill;
  } vec_t;

  localparam outs_t O_NONE = '0;
  localparam outs_t O_F1   = '{pc_en:1'b1, mem_read:1'b1, ir_write:1'b1, alu_src_b:2'b01, default:'0};
  localparam outs_t O_F0   = '{mem_read:1'b1, alu_src_b:2'b01, default:'0};
  localparam outs_t O_DEC  = '{alu_src_b:2'b11, default:'0};
  localparam outs_t O_MA   = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
  localparam outs_t O_MRD  = '{mem_read:1'b1, iord:1'b1, default:'0};
  localparam outs_t O_MWB  = '{reg_write:1'b1, mem_to_reg:1'b1, default:'0};
  localparam outs_t O_MWR  = '{mem_write:1'b1, iord:1'b1, default:'0};
  localparam outs_t O_EX   = '{alu_src_a:1'b1, alu_op:2'b10, default:'0};
  localparam outs_t O_RWB  = '{reg_write:1'b1, reg_dst:1'b1, default:'0};
  localparam outs_t O_BR1  = '{pc_en:1'b1, alu_src_a:1'b1, alu_op:2'b01, pc_source:2'b01, default:'0};
  localparam outs_t O_BR0  = '{alu_src_a:1'b1, alu_op:2'b01, pc_source:2'b01, default:'0};
  localparam outs_t O_J    = '{pc_en:1'b1, pc_source:2'b10, default:'0};
  localparam outs_t O_AWB  = '{reg_write:1'b1, default:'0};

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  vec_t v[64];
  int   nv;

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  function automatic outs_t actual_outs();
    outs_t a;
    a.pc_en      = bus.pc_en;
    a.pc_source  = bus.pc_source;
    a.iord       = bus.iord;
    a.mem_read   = bus.mem_read;
    a.mem_write  = bus.mem_write;
    a.ir_write   = bus.ir_write;
    a.mem_to_reg = bus.mem_to_reg;
    a.reg_dst    = bus.reg_dst;
    a.reg_write  = bus.reg_write;
    a.alu_src_a  = bus.alu_src_a;
    a.alu_src_b  = bus.alu_src_b;
    a.alu_op     = bus.alu_op;
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input outs_t o, input logic ill);
    v[nv] = '{op:op, z:z, rdy:rdy, st:st, o:o, ill:ill};
    nv++;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nv    = 0;
    //  op         z     rdy   state  outputs  illegal
    add(6'b000000, 1'b0, 1'b1, 4'd0,  O_NONE, 1'b0);  // 0 BOOT
    add(6'b000000, 1'b0, 1'b1, 4'd1,  O_F1,   1'b0);  // 1 FETCH
    add(6'b100011, 1'b0, 1'b1, 4'd2,  O_DEC,  1'b0);  // lw
    add(6'b100011, 1'b0, 1'b1, 4'd3,  O_MA,   1'b0);
    add(6'b100011, 1'b0, 1'b1, 4'd4,  O_MRD,  1'b0);
    add(6'b100011, 1'b0, 1'b1, 4'd5,  O_MWB,  1'b0);
    add(6'b100011, 1'b0, 1'b1, 4'd1,  O_F1,   1'b0);
    add(6'b101011, 1'b0, 1'b1, 4'd2,  O_DEC,  1'b0);  // sw, 3 waits
    add(6'b101011, 1'b0, 1'b1, 4'd3,  O_MA,   1'b0);
    add(6'b101011, 1'b0, 1'b0, 4'd6,  O_MWR,  1'b0);
    add(6'b101011, 1'b0, 1'b0, 4'd6,  O_MWR,  1'b0);
    add(6'b101011, 1'b0, 1'b0, 4'd6,  O_MWR,  1'b0);
    add(6'b101011, 1'b0, 1'b1, 4'd6,  O_MWR,  1'b0);
    add(6'b101011, 1'b0, 1'b0, 4'd1,  O_F0,   1'b0);  // fetch wait
    add(6'b101011, 1'b0, 1'b1, 4'd1,  O_F1,   1'b0);
    add(6'b000000, 1'b0, 1'b0, 4'd2,  O_DEC,  1'b0);  // R-type
    add(6'b000000, 1'b1, 1'b1, 4'd7,  O_EX,   1'b0);
    add(6'b000000, 1'b0, 1'b0, 4'd8,  O_RWB,  1'b0);
    add(6'b000000, 1'b0, 1'b1, 4'd1,  O_F1,   1'b0);
    add(6'b001000, 1'b0, 1'b0, 4'd2,  O_DEC,  1'b0);  // addi
    add(6'b001000, 1'b0, 1'b0, 4'd11, O_MA,   1'b0);
    add(6'b001000, 1'b0, 1'b0, 4'd12, O_AWB,  1'b0);
    add(6'b001000, 1'b0, 1'b1, 4'd1,  O_F1,   1'b0);
    add(6'b000100, 1'b1, 1'b1, 4'd2,  O_DEC,  1'b0);  // beq taken
    add(6'b000100, 1'b1, 1'b1, 4'd9,  O_BR1,  1'b0);
    add(6'b000100, 1'b1, 1'b1, 4'd1,  O_F1,   1'b0);
    add(6'b000101, 1'b1, 1'b1, 4'd2,  O_DEC,  1'b0);  // bne not taken
    add(6'b000101, 1'b1, 1'b1, 4'd9,  O_BR0,  1'b0);
    add(6'b000101, 1'b1, 1'b1, 4'd1,  O_F1,   1'b0);
    add(6'b000101, 1'b0, 1'b1, 4'd2,  O_DEC,  1'b0);  // bne taken
    add(6'b000101, 1'b0, 1'b1, 4'd9,  O_BR1,  1'b0);
    add(6'b000101, 1'b0, 1'b1, 4'd1,  O_F1,   1'b0);
    add(6'b000100, 1'b0, 1'b1, 4'd2,  O_DEC,  1'b0);  // beq not taken
    add(6'b000100, 1'b0, 1'b1, 4'd9,  O_BR0,  1'b0);
    add(6'b000100, 1'b0, 1'b1, 4'd1,  O_F1,   1'b0);
    add(6'b111111, 1'b0, 1'b1, 4'd2,  O_DEC,  1'b0);  // 35 illegal
    add(6'b111111, 1'b0, 1'b1, 4'd1,  O_F1,   1'b1);  // 36
    add(6'b000010, 1'b0, 1'b1, 4'd2,  O_DEC,  1'b1);  // j
    add(6'b000010, 1'b0, 1'b1, 4'd10, O_J,    1'b1);
    add(6'b000010, 1'b0, 1'b1, 4'd1,  O_F1,   1'b1);  // 39

    rst_n         = 1'b0;
    bus.opcode    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_outs", 32'(actual_outs()), 32'(O_NONE));
    chk("reset_illegal", 32'(bus.illegal_op), 32'd0);
`ifdef MCTRL_PERF_EN
    chk("reset_cycle_count", bus.cycle_count, 32'd0);
    chk("reset_instr_count", bus.instr_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      bus.opcode    = v[i].op;
      bus.zero      = v[i].z;
      bus.mem_ready = v[i].rdy;
      #1;
      chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'(v[i].st));
      chk($sformatf("vec%0d_outs", i), 32'(actual_outs()), 32'(v[i].o));
      chk($sformatf("vec%0d_illegal", i), 32'(bus.illegal_op), 32'(v[i].ill));
`ifdef MCTRL_PERF_EN
      if (i == 35 || i == 36) chk($sformatf("vec%0d_instr_count", i), bus.instr_count, 32'd8);
      if (i == 39) begin
        chk("vec39_instr_count", bus.instr_count, 32'd9);
        chk("vec39_cycle_count", bus.cycle_count, 32'd38);
      end
`endif
      @(negedge clk);
    end

    // lw stalled in MEM_RD, then reset asserted mid-access
    bus.opcode    = 6'b100011;
    bus.mem_ready = 1'b1;
    #1;
    chk("rst_seq_decode", 32'(bus.state), 32'd2);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_seq_memrd_state", 32'(bus.state), 32'd4);
    chk("rst_seq_memrd_read", 32'(bus.mem_read), 32'd1);
    @(negedge clk);
    #1;
    chk("rst_seq_memrd_hold", 32'(actual_outs()), 32'(O_MRD));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_seq_read_drop", 32'(bus.mem_read), 32'd0);
    chk("rst_seq_state_boot", 32'(bus.state), 32'd0);
    chk("rst_seq_illegal_clr", 32'(bus.illegal_op), 32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    chk("rst_seq_boot_outs", 32'(actual_outs()), 32'(O_NONE));
    @(negedge clk);
    #1;
    chk("rst_seq_refetch_state", 32'(bus.state), 32'd1);
    chk("rst_seq_refetch_outs", 32'(actual_outs()), 32'(O_F1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control unit for the MIPS datapath. Sequences the shared ALU, register file, single instruction/data memory port, IR and PC through fetch/decode/execute/memory/write-back steps. Decodes the 6-bit opcode held in the IR, waits on a memory-ready handshake, and drives every datapath mux select and write strobe. The separate ALU-control block consumes `alu_op`, and the ALU returns `zero` to this block.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  IR[31:26]
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completed the current access this cycle
- `pc_en`  out  1  PC load enable
- `pc_source`  out  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump address
- `iord`  out  1  memory address select: 0 PC, 1 ALUOut
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `ir_write`  out  1  IR load
- `mem_to_reg`  out  1  write-back select: 1 MDR, 0 ALUOut
- `reg_dst`  out  1  destination register select: 1 rd, 0 rt
- `reg_write`  out  1  register-file write
- `alu_src_a`  out  1  ALU A select: 0 PC, 1 register A
- `alu_src_b`  out  2  ALU B select: 00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2
- `alu_op`  out  2  00 add, 01 sub, 10 funct-directed
- `illegal_op`  out  1  sticky flag: an unsupported opcode was decoded
- `state`  out  4  current state, for debug
- `instr_count`  out  32  retired instructions (MCTRL_PERF_EN only)
- `cycle_count`  out  32  cycles since reset (MCTRL_PERF_EN only)

## Operation
- States:
  - BOOT=0
  - FETCH=1
  - DECODE=2
  - MEM_ADDR=3
  - MEM_RD=4
  - MEM_WB=5
  - MEM_WR=6
  - EXEC=7
  - R_WB=8
  - BRANCH=9
  - JUMP=10
  - ADDI_EX=11
  - ADDI_WB=12
- Transitions:
  - BOOT→FETCH unconditionally.
  - FETCH stays in FETCH until `mem_ready`, then →DECODE.
  - DECODE dispatches on `opcode`:
    - 000000 (R-type)→EXEC
    - 100011 (lw) and 101011 (sw)→MEM_ADDR
    - 000100 (beq) and 000101 (bne)→BRANCH
    - 000010 (j)→JUMP
    - 001000 (addi)→ADDI_EX
    - anything else: set `illegal_op`, →FETCH
  - MEM_ADDR→MEM_RD for lw, →MEM_WR for sw.
  - MEM_RD stays until `mem_ready`, then →MEM_WB.
  - MEM_WR stays until `mem_ready`, then →FETCH.
  - EXEC→R_WB; ADDI_EX→ADDI_WB.
  - MEM_WB, R_WB, ADDI_WB, BRANCH and JUMP all →FETCH.
- Outputs per state. Every output not listed is 0.
  - BOOT: all outputs 0.
  - FETCH: `mem_read`=1, `alu_src_b`=01. `ir_write` and `pc_en` equal `mem_ready`.
  - DECODE: `alu_src_b`=11. ALU computes the branch target into ALUOut.
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10.
  - MEM_RD: `mem_read`=1, `iord`=1.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1.
  - MEM_WR: `mem_write`=1, `iord`=1.
  - EXEC: `alu_src_a`=1, `alu_op`=10.
  - R_WB: `reg_write`=1, `reg_dst`=1.
  - BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_source`=01. `pc_en` = `zero` for beq, `~zero` for bne.
  - JUMP: `pc_en`=1, `pc_source`=10.
  - ADDI_EX: `alu_src_a`=1, `alu_src_b`=10.
  - ADDI_WB: `reg_write`=1.
- `mem_ready` is ignored outside FETCH, MEM_RD and MEM_WR.
- `opcode` is sampled in DECODE and in MEM_ADDR/BRANCH only. The IR is stable during those states by construction.
- `illegal_op` is cleared only by reset.

## Timing
- Moore outputs decode from the state register. `pc_en` and `ir_write` are Mealy terms (on `mem_ready` and `zero`), combinational in the same cycle.
- Reset:
  - `rst_n` low forces state=BOOT asynchronously, which drops all strobes immediately, including mid-memory access.
  - `illegal_op`=0; counters=0.
  - The first FETCH occurs 1 cycle after `rst_n` rises.
- Cycle counts with zero-wait memory:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq/bne: 3
  - j: 3
  - illegal: 2
- Each wait cycle in FETCH, MEM_RD or MEM_WR adds 1 cycle. The control outputs are held constant while waiting.

## Configuration
- MCTRL_PERF_EN defined:
  - `cycle_count` increments every cycle after BOOT.
  - `instr_count` increments on every transition into FETCH from MEM_WB, MEM_WR, R_WB, ADDI_WB, BRANCH or JUMP. Illegal opcodes do not count.
  - Both counters wrap at 2^32 (0xFFFFFFFF→0).
- MCTRL_PERF_EN undefined: the `instr_count` and `cycle_count` ports and their logic are absent.

## Structure
- Package `mctrl_pkg` holds:
  - the state encoding constants
  - the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI)
  - the `alu_op`, `alu_src_b` and `pc_source` encodings
- One sub-module, `mctrl_out_decode`, provides the purely combinational mapping from (state, opcode, zero, mem_ready) to outputs. The top holds only the state register, next-state logic, the sticky flag and the counters.

## Test plan
- Reset with `mem_ready`=1 → BOOT for 1 cycle with all strobes 0, then FETCH with `pc_en`=`ir_write`=1.
- lw (opcode 100011), zero-wait → state sequence 1,2,3,4,5,1; `reg_write`=1 and `mem_to_reg`=1 only in state 5.
- sw with `mem_ready` low for 3 cycles in MEM_WR → `mem_write`=1 and `iord`=1 held for 4 cycles, then FETCH; `reg_write` never asserted.
- beq with `zero`=1 → `pc_en`=1, `pc_source`=01 in BRANCH; bne with `zero`=1 → `pc_en`=0.
- Opcode 111111 → `illegal_op` rises and stays 1 through a following j (000010); `instr_count` is +1 only for the j (MCTRL_PERF_EN).
- `rst_n` pulled low during MEM_RD wait → `mem_read` drops to 0 in the same cycle; state=BOOT; `illegal_op`=0.
